// File: rtl/ucode_seq_if.sv
// Microsequencer port bundle: microword control, condition operands, and
// sequencer state observed by the datapath.
interface ucode_seq_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned CNT_W  = 3
);
  logic              hold;
  logic              ucode_trap;
  logic [2:0]        u_seq;
  logic [ADDR_W-1:0] u_addr;
  logic [ADDR_W-1:0] dispatch_addr;
  logic              u_rd_rs1_a;
  logic              rs1_0_l;
  logic              rs2_0_l;
  logic [ADDR_W-1:0] upc;
  logic [CNT_W-1:0]  stk_cnt;
  logic              stk_err;

  modport master (
    output hold, ucode_trap, u_seq, u_addr, dispatch_addr,
           u_rd_rs1_a, rs1_0_l, rs2_0_l,
    input  upc, stk_cnt, stk_err
  );

  modport slave (
    input  hold, ucode_trap, u_seq, u_addr, dispatch_addr,
           u_rd_rs1_a, rs1_0_l, rs2_0_l,
    output upc, stk_cnt, stk_err
  );
endinterface

// File: rtl/ucode_seq.sv
// Microprogram sequencer: next-uPC select, conditional branches, trap entry.
// Return stack for CALL/RET is built only when UCODE_SEQ_RSTACK_EN is defined.
module ucode_seq #(
  parameter int unsigned       ADDR_W    = 9,
  parameter int unsigned       STK_DEPTH = 4,
  parameter int unsigned       CNT_W     = 3,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'(9'h1F0)
) (
  input logic        clk,
  input logic        reset_l,
  ucode_seq_if.slave bus
);

  typedef enum logic [2:0] {
    SEQ_NEXT  = 3'b000,
    SEQ_JUMP  = 3'b001,
    SEQ_JCOND = 3'b010,
    SEQ_JMP2  = 3'b011,
    SEQ_CALL  = 3'b100,
    SEQ_RET   = 3'b101,
    SEQ_DISP  = 3'b110,
    SEQ_RSVD  = 3'b111
  } seq_op_e;

  if (STK_DEPTH < 1 || STK_DEPTH > (1 << CNT_W) - 1) begin : g_bad_cfg
    $error("ucode_seq: STK_DEPTH must be in 1 .. 2**CNT_W-1");
  end

  logic [ADDR_W-1:0] upc_q;
  logic [ADDR_W-1:0] upc_inc_c;
  logic [ADDR_W-1:0] upc_nxt_c;
  logic              cond_c;
  seq_op_e           op_c;

  assign cond_c    = ~(bus.u_rd_rs1_a ? bus.rs1_0_l : bus.rs2_0_l);
  assign upc_inc_c = upc_q + ADDR_W'(1);
  assign op_c      = seq_op_e'(bus.u_seq);
  assign bus.upc   = upc_q;

`ifdef UCODE_SEQ_RSTACK_EN
  localparam int unsigned IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

  logic [ADDR_W-1:0] stk_mem [STK_DEPTH];
  logic [CNT_W-1:0]  stk_cnt_q, stk_cnt_nxt_c;
  logic              stk_err_q, stk_err_nxt_c;
  logic              push_c;
  logic              advance_c;

  assign advance_c   = ~bus.ucode_trap & ~bus.hold;
  assign bus.stk_cnt = stk_cnt_q;
  assign bus.stk_err = stk_err_q;

  always_comb begin
    upc_nxt_c     = upc_inc_c;
    stk_cnt_nxt_c = stk_cnt_q;
    stk_err_nxt_c = stk_err_q;
    push_c        = 1'b0;
    case (op_c)
      SEQ_JUMP:  upc_nxt_c = bus.u_addr;
      SEQ_JCOND: upc_nxt_c = cond_c ? bus.u_addr : upc_inc_c;
      SEQ_JMP2:  upc_nxt_c = {bus.u_addr[ADDR_W-1:1], cond_c};
      SEQ_DISP:  upc_nxt_c = bus.dispatch_addr;
      SEQ_CALL: begin
        upc_nxt_c = bus.u_addr;
        // Full stack: still take the call, but drop the return address
        if (stk_cnt_q == CNT_W'(STK_DEPTH)) begin
          stk_err_nxt_c = 1'b1;
        end else begin
          push_c        = 1'b1;
          stk_cnt_nxt_c = stk_cnt_q + CNT_W'(1);
        end
      end
      SEQ_RET: begin
        if (stk_cnt_q == '0) begin
          upc_nxt_c     = '0;
          stk_err_nxt_c = 1'b1;
        end else begin
          upc_nxt_c     = stk_mem[IDX_W'(stk_cnt_q - CNT_W'(1))];
          stk_cnt_nxt_c = stk_cnt_q - CNT_W'(1);
        end
      end
      default:   upc_nxt_c = upc_inc_c;
    endcase
  end

  // Entries at or above stk_cnt are never read, so storage needs no reset
  always_ff @(posedge clk) begin
    if (advance_c && push_c) begin
      stk_mem[IDX_W'(stk_cnt_q)] <= upc_inc_c;
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      upc_q     <= '0;
      stk_cnt_q <= '0;
      stk_err_q <= 1'b0;
    end else if (bus.ucode_trap) begin
      upc_q     <= TRAP_VEC;
      stk_cnt_q <= '0;
      stk_err_q <= 1'b0;
    end else if (!bus.hold) begin
      upc_q     <= upc_nxt_c;
      stk_cnt_q <= stk_cnt_nxt_c;
      stk_err_q <= stk_err_nxt_c;
    end
  end
`else
  assign bus.stk_cnt = '0;
  assign bus.stk_err = 1'b0;

  // Without a stack, CALL degenerates to JUMP and RET to NEXT
  always_comb begin
    upc_nxt_c = upc_inc_c;
    case (op_c)
      SEQ_JUMP, SEQ_CALL: upc_nxt_c = bus.u_addr;
      SEQ_JCOND:          upc_nxt_c = cond_c ? bus.u_addr : upc_inc_c;
      SEQ_JMP2:           upc_nxt_c = {bus.u_addr[ADDR_W-1:1], cond_c};
      SEQ_DISP:           upc_nxt_c = bus.dispatch_addr;
      default:            upc_nxt_c = upc_inc_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      upc_q <= '0;
    end else if (bus.ucode_trap) begin
      upc_q <= TRAP_VEC;
    end else if (!bus.hold) begin
      upc_q <= upc_nxt_c;
    end
  end
`endif

endmodule

// File: tb/tb_ucode_seq.sv
// Directed self-checking bench for ucode_seq; stack scenarios follow
// UCODE_SEQ_RSTACK_EN, the same macro that configures the design.
module tb_ucode_seq;
  logic clk = 1'b0;
  logic reset_l = 1'b0;
  int   checks = 0;
  int   passes = 0;

  ucode_seq_if #(.ADDR_W(9), .CNT_W(3)) bus();

  ucode_seq #(.ADDR_W(9), .STK_DEPTH(4), .CNT_W(3), .TRAP_VEC(9'h1F0)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Advance one edge and settle 1 ns past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] seq, input logic [8:0] addr);
    bus.u_seq  = seq;
    bus.u_addr = addr;
  endtask

  task automatic test_reset();
    bus.hold = 1'b0; bus.ucode_trap = 1'b0; bus.u_seq = 3'b000;
    bus.u_addr = '0; bus.dispatch_addr = '0;
    bus.u_rd_rs1_a = 1'b1; bus.rs1_0_l = 1'b1; bus.rs2_0_l = 1'b1;
    reset_l = 1'b0;
    #12;
    checks++; if (bus.upc !== 9'h000) $display("FAIL reset_upc: got %h exp 000", bus.upc); else passes++;
    checks++; if (bus.stk_cnt !== 3'd0) $display("FAIL reset_cnt: got %0d exp 0", bus.stk_cnt); else passes++;
    checks++; if (bus.stk_err !== 1'b0) $display("FAIL reset_err: got %b exp 0", bus.stk_err); else passes++;
    @(negedge clk);
    reset_l = 1'b1;
  endtask

  task automatic test_next();
    logic [8:0] exp_upc;
    set_op(3'b000, 9'h000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_upc = 9'(i);
      checks++; if (bus.upc !== exp_upc) $display("FAIL next_%0d: got %h exp %h", i, bus.upc, exp_upc); else passes++;
    end
    set_op(3'b001, 9'h1FF); tick();
    checks++; if (bus.upc !== 9'h1FF) $display("FAIL jump_1ff: got %h exp 1ff", bus.upc); else passes++;
    set_op(3'b000, 9'h000); tick();
    checks++; if (bus.upc !== 9'h000) $display("FAIL next_wrap: got %h exp 000", bus.upc); else passes++;
    set_op(3'b111, 9'h055); tick();
    checks++; if (bus.upc !== 9'h001) $display("FAIL seq111: got %h exp 001", bus.upc); else passes++;
  endtask

  task automatic test_cond();
    set_op(3'b010, 9'h040); bus.u_rd_rs1_a = 1'b1; bus.rs1_0_l = 1'b0; bus.rs2_0_l = 1'b1;
    tick();
    checks++; if (bus.upc !== 9'h040) $display("FAIL jcond_taken: got %h exp 040", bus.upc); else passes++;
    bus.rs1_0_l = 1'b1; bus.rs2_0_l = 1'b0;
    tick();
    checks++; if (bus.upc !== 9'h041) $display("FAIL jcond_fall: got %h exp 041", bus.upc); else passes++;
    set_op(3'b011, 9'h081); bus.u_rd_rs1_a = 1'b0; bus.rs2_0_l = 1'b0; bus.rs1_0_l = 1'b1;
    tick();
    checks++; if (bus.upc !== 9'h081) $display("FAIL jmp2_one: got %h exp 081", bus.upc); else passes++;
    bus.rs2_0_l = 1'b1; bus.rs1_0_l = 1'b0;
    tick();
    checks++; if (bus.upc !== 9'h080) $display("FAIL jmp2_zero: got %h exp 080", bus.upc); else passes++;
    set_op(3'b110, 9'h000); bus.dispatch_addr = 9'h133;
    tick();
    checks++; if (bus.upc !== 9'h133) $display("FAIL dispatch: got %h exp 133", bus.upc); else passes++;
  endtask

  task automatic test_call_ret();
`ifdef UCODE_SEQ_RSTACK_EN
    logic [8:0] ret_exp [4];
    logic [8:0] tgt;
    set_op(3'b001, 9'h010); tick();
    set_op(3'b100, 9'h100); tick();
    checks++; if (bus.upc !== 9'h100 || bus.stk_cnt !== 3'd1) $display("FAIL call: got upc %h cnt %0d exp 100/1", bus.upc, bus.stk_cnt); else passes++;
    set_op(3'b101, 9'h000); tick();
    checks++; if (bus.upc !== 9'h011 || bus.stk_cnt !== 3'd0 || bus.stk_err !== 1'b0) $display("FAIL ret: got upc %h cnt %0d err %b exp 011/0/0", bus.upc, bus.stk_cnt, bus.stk_err); else passes++;
    // Nest five calls from 0x011; the fifth overflows
    ret_exp[0] = 9'h012; ret_exp[1] = 9'h101; ret_exp[2] = 9'h111; ret_exp[3] = 9'h121;
    for (int i = 0; i < 5; i++) begin
      tgt = 9'h100 + 9'(i * 16);
      set_op(3'b100, tgt); tick();
    end
    checks++; if (bus.upc !== 9'h140 || bus.stk_cnt !== 3'd4 || bus.stk_err !== 1'b1) $display("FAIL call_ovf: got upc %h cnt %0d err %b exp 140/4/1", bus.upc, bus.stk_cnt, bus.stk_err); else passes++;
    for (int i = 3; i >= 0; i--) begin
      set_op(3'b101, 9'h000); tick();
      checks++; if (bus.upc !== ret_exp[i] || bus.stk_cnt !== 3'(i)) $display("FAIL ret_lifo_%0d: got upc %h cnt %0d exp %h/%0d", i, bus.upc, bus.stk_cnt, ret_exp[i], i); else passes++;
    end
    tick();
    checks++; if (bus.upc !== 9'h000 || bus.stk_cnt !== 3'd0 || bus.stk_err !== 1'b1) $display("FAIL ret_unf: got upc %h cnt %0d err %b exp 000/0/1", bus.upc, bus.stk_cnt, bus.stk_err); else passes++;
`else
    set_op(3'b100, 9'h100); tick();
    checks++; if (bus.upc !== 9'h100 || bus.stk_cnt !== 3'd0) $display("FAIL call_nostk: got upc %h cnt %0d exp 100/0", bus.upc, bus.stk_cnt); else passes++;
    set_op(3'b101, 9'h000); tick();
    checks++; if (bus.upc !== 9'h101 || bus.stk_err !== 1'b0) $display("FAIL ret_nostk: got upc %h err %b exp 101/0", bus.upc, bus.stk_err); else passes++;
`endif
  endtask

  task automatic test_trap_hold();
    logic [2:0] exp_cnt;
`ifdef UCODE_SEQ_RSTACK_EN
    exp_cnt = 3'd1;
`else
    exp_cnt = 3'd0;
`endif
    set_op(3'b100, 9'h020); tick();
    set_op(3'b100, 9'h030); tick();
    bus.hold = 1'b1; bus.ucode_trap = 1'b1; tick();
    checks++; if (bus.upc !== 9'h1F0 || bus.stk_cnt !== 3'd0 || bus.stk_err !== 1'b0) $display("FAIL trap: got upc %h cnt %0d err %b exp 1f0/0/0", bus.upc, bus.stk_cnt, bus.stk_err); else passes++;
    bus.hold = 1'b0; bus.ucode_trap = 1'b0;
    set_op(3'b100, 9'h0A0); tick();
    bus.hold = 1'b1; set_op(3'b101, 9'h000);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.upc !== 9'h0A0 || bus.stk_cnt !== exp_cnt) $display("FAIL hold_%0d: got upc %h cnt %0d exp 0a0/%0d", i, bus.upc, bus.stk_cnt, exp_cnt); else passes++;
    end
    bus.hold = 1'b0; tick();
`ifdef UCODE_SEQ_RSTACK_EN
    checks++; if (bus.upc !== 9'h1F1 || bus.stk_cnt !== 3'd0) $display("FAIL hold_release: got upc %h cnt %0d exp 1f1/0", bus.upc, bus.stk_cnt); else passes++;
`else
    checks++; if (bus.upc !== 9'h0A1) $display("FAIL hold_release: got upc %h exp 0a1", bus.upc); else passes++;
`endif
  endtask

  task automatic test_reset_mid();
    set_op(3'b100, 9'h150); tick();
    set_op(3'b101, 9'h000);
    #2 reset_l = 1'b0;
    #1;
    checks++; if (bus.upc !== 9'h000 || bus.stk_cnt !== 3'd0 || bus.stk_err !== 1'b0) $display("FAIL async_reset: got upc %h cnt %0d err %b exp 000/0/0", bus.upc, bus.stk_cnt, bus.stk_err); else passes++;
    @(negedge clk);
    reset_l = 1'b1;
    set_op(3'b000, 9'h000); tick();
    checks++; if (bus.upc !== 9'h001 || bus.stk_cnt !== 3'd0) $display("FAIL post_reset: got upc %h cnt %0d exp 001/0", bus.upc, bus.stk_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_next();
    test_cond();
    test_call_ret();
    test_trap_hold();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not finish, got %0d/%0d", passes, checks);
    $fatal(1);
  end
endmodule
